enable_receiver: RTL and testbench

- Receiving end of the gated nibble interface, where `enab` qualifies a pair of 4-bit words (A, B).
- Samples {A_in, B_in} on every clock edge where `enab` is high and queues each pair in a small FIFO.
- Presents queued pairs downstream through a valid/ready handshake.
- Counts pairs lost to overflow, so the consumer side of the enable path can be buffered and checked.

---
 rtl/enable_receiver_pkg.sv | 9 +
 rtl/enable_fifo.sv | 62 ++++++
 rtl/enable_receiver.sv | 85 ++++++++
 tb/tb_enable_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/enable_receiver_pkg.sv
// Shared defaults for the enable_receiver slice. Each FIFO entry packs A into the
// upper DATA_W bits and B into the lower DATA_W bits.
package enable_receiver_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/enable_fifo.sv
// Generic first-word fall-through synchronous FIFO with an explicit occupancy counter.
// The head word is read combinationally from registered storage and reads as 0 when empty.
module enable_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_push_ok;
   logic          w_pop_ok;

   // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);

   assign full  = (r_level == (AW+1)'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/enable_receiver.sv
// Receiver for the gated nibble interface: captures {A_in,B_in} into a FIFO, counts overflow drops.
// Define ENAB_EDGE_CAPTURE_EN to capture only on the rising edge of enab instead of every enab-high cycle.
module enable_receiver
   import enable_receiver_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enab,
   input  logic [DATA_W-1:0]      A_in,
   input  logic [DATA_W-1:0]      B_in,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      A_out,
   output logic [DATA_W-1:0]      B_out,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty,
   output logic [CNT_W-1:0]       drop_cnt
);

   logic                  w_capture;
   logic                  w_pop;
   logic                  w_drop;
   logic                  w_full;
   logic                  w_empty;
   logic [2*DATA_W-1:0]   w_head;
   logic [CNT_W-1:0]      r_drop_cnt;

`ifdef ENAB_EDGE_CAPTURE_EN
   logic r_enab_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_enab_q <= 1'b0;
      end else begin
         r_enab_q <= enab;
      end
   end

   assign w_capture = enab && !r_enab_q;
`else
   assign w_capture = enab;
`endif

   assign w_pop  = !w_empty && out_ready;
   // A capture is lost only when the FIFO is full and no pop makes room this cycle.
   assign w_drop = w_capture && w_full && !w_pop;

   enable_fifo #(
      .W     (2*DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_capture),
      .pop   (w_pop),
      .din   ({A_in, B_in}),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != '1)) begin
         r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end else begin
         r_drop_cnt <= r_drop_cnt;
      end
   end

   assign out_valid = !w_empty;
   assign A_out     = w_head[2*DATA_W-1:DATA_W];
   assign B_out     = w_head[DATA_W-1:0];
   assign full      = w_full;
   assign empty     = w_empty;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_enable_receiver.sv
// Scoreboard bench for enable_receiver: stimulus queues expected pairs, a negedge monitor checks pops.
module tb_enable_receiver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enab;
   logic [3:0] A_in;
   logic [3:0] B_in;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] A_out;
   logic [3:0] B_out;
   logic [2:0] level;
   logic       full;
   logic       empty;
   logic [7:0] drop_cnt;

   logic [7:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   enable_receiver dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enab      (enab),
      .A_in      (A_in),
      .B_in      (B_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .A_out     (A_out),
      .B_out     (B_out),
      .level     (level),
      .full      (full),
      .empty     (empty),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Monitor: every handshake the DUT will complete at the next posedge must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got=%h expected none", {A_out, B_out});
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if ({A_out, B_out} !== e) begin
               errors++;
               $display("FAIL pop_data got=%h expected=%h", {A_out, B_out}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One capture; in edge mode enab must drop between captures.
   task automatic send(input logic [3:0] a, input logic [3:0] b);
      enab = 1'b1;
      A_in = a;
      B_in = b;
      tick();
`ifdef ENAB_EDGE_CAPTURE_EN
      enab = 1'b0;
      tick();
`endif
   endtask

   initial begin
      rst_n = 1'b0; enab = 1'b0; A_in = 4'h0; B_in = 4'h0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_data", 32'({A_out, B_out}), 32'h00);

      // Gating: data with enab low is ignored
      enab = 1'b0; A_in = 4'b1110; B_in = 4'b0100;
      for (int i = 0; i < 3; i++) tick();
      chk("gate_empty", 32'(empty), 32'd1);
      chk("gate_level", 32'(level), 32'd0);
      chk("gate_valid", 32'(out_valid), 32'd0);

      // Single capture, fall-through latency of one edge
      exp_q.push_back(8'hE5);
      enab = 1'b1; A_in = 4'b1110; B_in = 4'b0101;
      tick();
      enab = 1'b0;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'({A_out, B_out}), 32'hE5);
      chk("single_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_empty", 32'(empty), 32'd1);

      // Overflow: 6 captures into a 4-deep FIFO
      exp_q.push_back(8'h0F); exp_q.push_back(8'h1E);
      exp_q.push_back(8'h2D); exp_q.push_back(8'h3C);
      for (int i = 0; i < 6; i++) send(4'(i), ~4'(i));
      enab = 1'b0;
      chk("ovf_level", 32'(level), 32'd4);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_drop", 32'(drop_cnt), 32'd2);

      // Push and pop together while full: no drop, head advances, 0xA becomes tail
      exp_q.push_back(8'hA5);
      enab = 1'b1; out_ready = 1'b1; A_in = 4'hA; B_in = 4'h5;
      tick();
      enab = 1'b0; out_ready = 1'b0;
      chk("simul_level", 32'(level), 32'd4);
      chk("simul_drop", 32'(drop_cnt), 32'd2);
      chk("simul_head", 32'(A_out), 32'h1);

      // Drain: monitor sees 1,2,3,A
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_data0", 32'({A_out, B_out}), 32'h00);

      // Reset mid-operation with level=3, drop_cnt=1
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rst2_drop", 32'(drop_cnt), 32'd0);
      exp_q.push_back(8'h78); exp_q.push_back(8'h87);
      exp_q.push_back(8'h96); exp_q.push_back(8'hA5);
      for (int i = 0; i < 5; i++) send(4'(7 + i), ~4'(7 + i));
      enab = 1'b0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("mid_level", 32'(level), 32'd3);
      chk("mid_drop", 32'(drop_cnt), 32'd1);
      rst_n = 1'b0; tick();
      exp_q.delete();
      rst_n = 1'b1;
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_data", 32'({A_out, B_out}), 32'h00);
      chk("midrst_drop", 32'(drop_cnt), 32'd0);

      // Drop counter saturates at 255
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h5A);
      for (int i = 0; i < 300; i++) send(4'h5, 4'hA);
      enab = 1'b0;
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      chk("sat_level", 32'(level), 32'd4);
      rst_n = 1'b0; tick();
      exp_q.delete();
      rst_n = 1'b1;

`ifdef ENAB_EDGE_CAPTURE_EN
      // Held-high enab yields one capture per assertion
      exp_q.push_back(8'h31); exp_q.push_back(8'h32);
      enab = 1'b1; A_in = 4'h3; B_in = 4'h1;
      for (int i = 0; i < 5; i++) tick();
      chk("edge_level1", 32'(level), 32'd1);
      enab = 1'b0; tick();
      enab = 1'b1; B_in = 4'h2; tick();
      enab = 1'b0;
      chk("edge_level2", 32'(level), 32'd2);
`else
      // Held-high enab captures every cycle
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h31);
      enab = 1'b1; A_in = 4'h3; B_in = 4'h1;
      for (int i = 0; i < 3; i++) tick();
      enab = 1'b0;
      chk("level_held", 32'(level), 32'd3);
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      chk("final_empty", 32'(empty), 32'd1);
      chk("final_level", 32'(level), 32'd0);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
